// File: rtl/noise_pkg.sv
// ============================================================================
// Module      : noise_pkg
// Description : Shared widths, threshold default and state encoding for the
//               impulse-noise marker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noise_pkg;

    localparam int DW_DEF     = 7;
    localparam int THRESH_DEF = 32;
    localparam int FLAG_BIT   = DW_DEF;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/noise_marker_if.sv
// ============================================================================
// Module      : noise_marker_if
// Description : Sample-in / tagged-byte-out stream bundle for noise_marker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface noise_marker_if #(
    parameter int DW = 7
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic [DW:0]   out_data;

    modport master (
        output in_valid,
        output in_data,
        output flush,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  flush,
        output out_valid,
        output out_data
    );
endinterface

`default_nettype wire

// File: rtl/noise_marker_abs_diff.sv
// ============================================================================
// Module      : abs_diff
// Description : Combinational |a-b| with sign of (a-b), unsigned operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module abs_diff #(
    parameter int DW = 7
) (
    input  wire logic [DW-1:0] a,
    input  wire logic [DW-1:0] b,
    output logic      [DW:0]   mag,
    output logic               neg
);
    logic signed [DW:0] w_diff;

    // One extra bit holds the full signed range of a difference of two
    // zero-extended DW-bit values, so no saturation is ever needed.
    assign w_diff = $signed({1'b0, a}) - $signed({1'b0, b});
    assign neg    = w_diff[DW];
    assign mag    = w_diff[DW] ? $unsigned(-w_diff) : $unsigned(w_diff);
endmodule

`default_nettype wire

// File: rtl/noise_marker.sv
// ============================================================================
// Module      : noise_marker
// Description : Buffers a prev/cur/next sample window and tags isolated
//               spikes as impulse noise in bit DW of the output byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noise_marker
    import noise_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  wire logic      clk,
    input  wire logic      rstn,
    noise_marker_if.slave  bus
);
    localparam logic [DW:0] C_THRESH = THRESH[DW:0];

    state_t        state_q,     state_d;
    logic [DW-1:0] prev_q,      prev_d;
    logic [DW-1:0] cur_q,       cur_d;
    logic          out_valid_q, out_valid_d;
    logic [DW:0]   out_data_q,  out_data_d;

    logic [DW-1:0] w_next;
    logic [DW:0]   w_mag_p, w_mag_n;
    logic          w_neg_p, w_neg_n;
    logic          w_flag;

    // A flush has no successor, so comparing cur with itself forces flag=0.
    assign w_next = bus.in_valid ? bus.in_data : cur_q;

    abs_diff #(.DW(DW)) u_diff_prev (
        .a   (cur_q),
        .b   (prev_q),
        .mag (w_mag_p),
        .neg (w_neg_p)
    );

    abs_diff #(.DW(DW)) u_diff_next (
        .a   (cur_q),
        .b   (w_next),
        .mag (w_mag_n),
        .neg (w_neg_n)
    );

    assign w_flag = (w_mag_p > C_THRESH) && (w_mag_n > C_THRESH) &&
                    (w_neg_p == w_neg_n);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (bus.in_valid) begin
                    cur_d   = bus.in_data;
                    prev_d  = bus.in_data;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                // in_valid takes priority; a simultaneous flush is dropped.
                if (bus.in_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {w_flag, cur_q};
                    prev_d      = cur_q;
                    cur_d       = bus.in_data;
                end else if (bus.flush) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {w_flag, cur_q};
                    state_d     = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_EMPTY;
            prev_q      <= '0;
            cur_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

`default_nettype wire
